// File: rtl/dfdd_ctrl_pkg.sv
// Shared types and address-map helpers for the depth-datapath frame sequencer.
package dfdd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_GAP,
    ST_DRAIN
  } state_e;

  typedef enum logic [2:0] {
    F_NONE,
    F_W,
    F_WT,
    F_A,
    F_B,
    F_R,
    F_CC,
    F_RC
  } field_e;

  typedef struct packed {
    field_e     field;
    logic [5:0] idx;
    logic       hit;
  } cfg_dec_t;

  localparam int ADDR_WT = 6;
  localparam int BASE_A  = 7;

  function automatic int base_b(int scales, int nz);
    return BASE_A + scales * nz;
  endfunction

  function automatic int base_r(int scales, int nz);
    return base_b(scales, nz) + scales * nz;
  endfunction

  function automatic int base_c(int scales, int nz);
    return base_r(scales, nz) + nz;
  endfunction

  // Flat address -> field plus index within that field's array.
  function automatic cfg_dec_t cfg_decode(logic [5:0] addr, int scales, int nz);
    cfg_dec_t d;
    int       a;
    a = {26'd0, addr};
    d = '{field: F_NONE, idx: 6'd0, hit: 1'b0};
    if (a < 3 * scales) begin
      d = '{field: F_W, idx: 6'(a), hit: 1'b1};
    end else if (a == ADDR_WT) begin
      d = '{field: F_WT, idx: 6'd0, hit: 1'b1};
    end else if (a >= BASE_A && a < base_b(scales, nz)) begin
      d = '{field: F_A, idx: 6'(a - BASE_A), hit: 1'b1};
    end else if (a >= base_b(scales, nz) && a < base_r(scales, nz)) begin
      d = '{field: F_B, idx: 6'(a - base_b(scales, nz)), hit: 1'b1};
    end else if (a >= base_r(scales, nz) && a < base_c(scales, nz)) begin
      d = '{field: F_R, idx: 6'(a - base_r(scales, nz)), hit: 1'b1};
    end else if (a == base_c(scales, nz)) begin
      d = '{field: F_CC, idx: 6'd0, hit: 1'b1};
    end else if (a == base_c(scales, nz) + 1) begin
      d = '{field: F_RC, idx: 6'd0, hit: 1'b1};
    end
    return d;
  endfunction

endpackage

// File: rtl/dfdd_cfg_regfile.sv
// Live coefficient file written by the config port, plus a shadow copy that
// the datapath sees and that only changes on snapshot_i.
module dfdd_cfg_regfile
  import dfdd_ctrl_pkg::*;
#(
  parameter int SCALES   = 2,
  parameter int NO_ZONES = 8
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    we_i,
  input  logic [5:0]                              addr_i,
  input  logic [15:0]                             data_i,
  input  logic                                    snapshot_i,
  output logic [SCALES-1:0][2:0][15:0]            w_o,
  output logic [15:0]                             w_t_o,
  output logic [SCALES-1:0][NO_ZONES-1:0][15:0]   a_o,
  output logic [SCALES-1:0][NO_ZONES-1:0][15:0]   b_o,
  output logic [NO_ZONES-1:0][15:0]               r_squared_o,
  output logic [15:0]                             col_center_o,
  output logic [15:0]                             row_center_o
);

  logic [SCALES-1:0][2:0][15:0]          w_q,  sh_w_q;
  logic [SCALES-1:0][NO_ZONES-1:0][15:0] a_q,  sh_a_q;
  logic [SCALES-1:0][NO_ZONES-1:0][15:0] b_q,  sh_b_q;
  logic [NO_ZONES-1:0][15:0]             r_q,  sh_r_q;
  logic [15:0]                           wt_q, sh_wt_q;
  logic [15:0]                           cc_q, sh_cc_q;
  logic [15:0]                           rc_q, sh_rc_q;
  cfg_dec_t                              dec;
  int                                    di;

  assign dec = cfg_decode(addr_i, SCALES, NO_ZONES);
  assign di  = {26'd0, dec.idx};

  // Snapshot reads the pre-write live value, so a write in the LOAD cycle
  // only reaches the shadow at the following frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_q <= '0;  a_q <= '0;  b_q <= '0;  r_q <= '0;
      wt_q <= '0; cc_q <= '0; rc_q <= '0;
      sh_w_q <= '0;  sh_a_q <= '0;  sh_b_q <= '0;  sh_r_q <= '0;
      sh_wt_q <= '0; sh_cc_q <= '0; sh_rc_q <= '0;
    end else begin
      if (we_i && dec.hit) begin
        for (int s = 0; s < SCALES; s++) begin
          for (int k = 0; k < 3; k++)
            if (dec.field == F_W && di == s * 3 + k) w_q[s][k] <= data_i;
          for (int z = 0; z < NO_ZONES; z++) begin
            if (dec.field == F_A && di == s * NO_ZONES + z) a_q[s][z] <= data_i;
            if (dec.field == F_B && di == s * NO_ZONES + z) b_q[s][z] <= data_i;
          end
        end
        for (int z = 0; z < NO_ZONES; z++)
          if (dec.field == F_R && di == z) r_q[z] <= data_i;
        if (dec.field == F_WT) wt_q <= data_i;
        if (dec.field == F_CC) cc_q <= data_i;
        if (dec.field == F_RC) rc_q <= data_i;
      end
      if (snapshot_i) begin
        sh_w_q  <= w_q;  sh_a_q  <= a_q;  sh_b_q  <= b_q;  sh_r_q <= r_q;
        sh_wt_q <= wt_q; sh_cc_q <= cc_q; sh_rc_q <= rc_q;
      end
    end
  end

  assign w_o          = sh_w_q;
  assign w_t_o        = sh_wt_q;
  assign a_o          = sh_a_q;
  assign b_o          = sh_b_q;
  assign r_squared_o  = sh_r_q;
  assign col_center_o = sh_cc_q;
  assign row_center_o = sh_rc_q;

endmodule

// File: rtl/dfdd_frame_sequencer.sv
// Frame sequencer: pixel handshake, coordinate generation, row gaps,
// coefficient snapshot per frame and datapath output counting.
module dfdd_frame_sequencer
  import dfdd_ctrl_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 50,
  parameter int IMAGE_HEIGHT = 50,
  parameter int SCALES       = 2,
  parameter int NO_ZONES     = 8,
  parameter int ROW_GAP      = 4
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    start_i,
  input  logic                                    cont_i,
  input  logic [7:0]                              pix_plus_i,
  input  logic [7:0]                              pix_minus_i,
  input  logic                                    pix_valid_i,
  output logic                                    pix_ready_o,
  input  logic                                    cfg_we_i,
  input  logic [5:0]                              cfg_addr_i,
  input  logic [15:0]                             cfg_data_i,
  output logic [7:0]                              rho_plus_o,
  output logic [7:0]                              rho_minus_o,
  output logic [15:0]                             col_o,
  output logic [15:0]                             row_o,
  output logic                                    valid_o,
  output logic [SCALES-1:0][2:0][15:0]            w_o,
  output logic [15:0]                             w_t_o,
  output logic [SCALES-1:0][NO_ZONES-1:0][15:0]   a_o,
  output logic [SCALES-1:0][NO_ZONES-1:0][15:0]   b_o,
  output logic [NO_ZONES-1:0][15:0]               r_squared_o,
  output logic [15:0]                             col_center_o,
  output logic [15:0]                             row_center_o,
  input  logic                                    dp_valid_i,
  output logic                                    busy_o,
  output logic                                    frame_done_o,
  output logic                                    overrun_o
);

  localparam logic [15:0] NPIX     = 16'(IMAGE_WIDTH * IMAGE_HEIGHT);
  localparam logic [15:0] LAST_COL = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMAGE_HEIGHT - 1);
  localparam logic [15:0] GAP_INIT = 16'((ROW_GAP > 0) ? ROW_GAP - 1 : 0);

  state_e      state_q, state_d;
  logic [15:0] col_cnt_q, row_cnt_q, out_cnt_q, gap_cnt_q;
  logic [15:0] col_q, row_q;
  logic [7:0]  rho_p_q, rho_m_q;
  logic        valid_q, ready_q, busy_q, done_q, ovr_q;
  logic        xfer, last_col, last_row, snapshot;

  assign xfer     = pix_valid_i && ready_q;
  assign last_col = (col_cnt_q == LAST_COL);
  assign last_row = (row_cnt_q == LAST_ROW);
  assign snapshot = (state_q == ST_LOAD);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_i) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_STREAM;
      ST_STREAM: if (xfer && last_col) begin
                   if (last_row)         state_d = ST_DRAIN;
                   else if (ROW_GAP > 0) state_d = ST_GAP;
                 end
      ST_GAP:    if (gap_cnt_q == 16'd0) state_d = ST_STREAM;
      ST_DRAIN:  if (out_cnt_q == NPIX) state_d = cont_i ? ST_LOAD : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      col_cnt_q <= '0; row_cnt_q <= '0; out_cnt_q <= '0; gap_cnt_q <= '0;
      col_q     <= '0; row_q     <= '0; rho_p_q   <= '0; rho_m_q   <= '0;
      valid_q   <= 1'b0; ready_q <= 1'b0; busy_q <= 1'b0;
      done_q    <= 1'b0; ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Moore outputs registered from the next state so they line up with it.
      ready_q <= (state_d == ST_STREAM);
      busy_q  <= (state_d != ST_IDLE);
      valid_q <= xfer;
      done_q  <= (state_q == ST_DRAIN) && (out_cnt_q == NPIX);

      if (xfer) begin
        rho_p_q <= pix_plus_i;
        rho_m_q <= pix_minus_i;
        col_q   <= col_cnt_q;
        row_q   <= row_cnt_q;
        if (last_col) begin
          col_cnt_q <= '0;
          row_cnt_q <= row_cnt_q + 16'd1;
        end else begin
          col_cnt_q <= col_cnt_q + 16'd1;
        end
      end

      if (state_q == ST_STREAM)   gap_cnt_q <= GAP_INIT;
      else if (state_q == ST_GAP) gap_cnt_q <= gap_cnt_q - 16'd1;

      if (state_q == ST_LOAD) begin
        col_cnt_q <= '0;
        row_cnt_q <= '0;
        out_cnt_q <= '0;
      end else if (state_q != ST_IDLE && dp_valid_i) begin
        if (out_cnt_q == NPIX) ovr_q <= 1'b1;
        else                   out_cnt_q <= out_cnt_q + 16'd1;
      end
    end
  end

  dfdd_cfg_regfile #(
    .SCALES   (SCALES),
    .NO_ZONES (NO_ZONES)
  ) u_regfile (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .we_i         (cfg_we_i),
    .addr_i       (cfg_addr_i),
    .data_i       (cfg_data_i),
    .snapshot_i   (snapshot),
    .w_o          (w_o),
    .w_t_o        (w_t_o),
    .a_o          (a_o),
    .b_o          (b_o),
    .r_squared_o  (r_squared_o),
    .col_center_o (col_center_o),
    .row_center_o (row_center_o)
  );

  assign pix_ready_o  = ready_q;
  assign rho_plus_o   = rho_p_q;
  assign rho_minus_o  = rho_m_q;
  assign col_o        = col_q;
  assign row_o        = row_q;
  assign valid_o      = valid_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign overrun_o    = ovr_q;

endmodule

// File: doc/dfdd_frame_sequencer.md
# dfdd_frame_sequencer

Frame-level controller for the `dual_scale_wrapper_fp16` depth datapath. It accepts uint8 ρ+/ρ− pixel pairs from an upstream source over a valid/ready handshake and generates `col`/`row` coordinates and per-pixel `valid`. It inserts programmable row gaps and holds a register file of datapath coefficients (w, w_t, a, b, r_squared, centres), snapshotting it into shadow registers at each frame start. It counts datapath outputs to detect frame completion.

## Interface
- `IMAGE_WIDTH`, 50, pixels per row
- `IMAGE_HEIGHT`, 50, rows per frame
- `SCALES`, 2, datapath scales
- `NO_ZONES`, 8, radial zones per scale
- `ROW_GAP`, 4, idle cycles inserted after each row except the last; 0 disables the gap
- `clk_i`  in  1  clock
- `rst_i`  in  1  synchronous, active-high reset
- `start_i`  in  1  start one frame; honoured only in IDLE
- `cont_i`  in  1  continuous mode; sampled at frame done
- `pix_plus_i`, `pix_minus_i`  in  8 each  upstream pixel pair
- `pix_valid_i`  in  1  upstream valid
- `pix_ready_o`  out  1  sequencer ready
- `cfg_we_i`  in  1  register write strobe
- `cfg_addr_i`  in  6  register address
- `cfg_data_i`  in  16  fp16 or integer word
- `rho_plus_o`, `rho_minus_o`  out  8 each  to datapath `i_rho_*_uint8_i`
- `col_o`, `row_o`  out  16 each  pixel coordinates
- `valid_o`  out  1  pixel valid to datapath
- `w_o[SCALES][3]`, `w_t_o`, `a_o[SCALES][NO_ZONES]`, `b_o[SCALES][NO_ZONES]`, `r_squared_o[NO_ZONES]`, `col_center_o`, `row_center_o`  out  16 each  shadow coefficients
- `dp_valid_i`  in  1  datapath `valid_o`
- `busy_o`  out  1  high in any state other than IDLE
- `frame_done_o`  out  1  one-cycle pulse at frame completion
- `overrun_o`  out  1  sticky flag: extra datapath outputs

## Operation
- **Address map** (A = 7, B = A + SCALES·NO_ZONES, R = B + SCALES·NO_ZONES, C = R + NO_ZONES; defaults give C = 47):
  - 0..3·SCALES−1: w[s][k] at s·3+k
  - 6: w_t
  - A+s·NO_ZONES+z: a[s][z]
  - B+s·NO_ZONES+z: b[s][z]
  - R+z: r_squared[z]
  - C: col_center
  - C+1: row_center
  - Writes to addresses above C+1 are ignored.
- Writes always land in the live file. The shadow file is copied from the live file only in LOAD.
- A write in the same cycle as LOAD is not captured by that snapshot; it takes effect from the next frame.
- **States:**
  - IDLE: `start_i` → LOAD.
  - LOAD: copy live → shadow, clear col/row/output counters → STREAM.
  - STREAM: `pix_ready_o` = 1. A transfer (`pix_valid_i` & `pix_ready_o`) registers the pair and coordinates and pulses `valid_o`. col increments on each transfer.
    - At col = W−1: col ← 0, row increments, and go to ROW_GAP if ROW_GAP > 0 and this is not the last row.
    - At the last pixel (col W−1, row H−1) → DRAIN.
  - ROW_GAP: `pix_ready_o` = 0 for exactly ROW_GAP cycles → STREAM.
  - DRAIN: `pix_ready_o` = 0. Wait until the output count equals W·H, pulse `frame_done_o`, then go to LOAD if `cont_i` = 1, else IDLE.
- **Output counter:**
  - 16-bit; increments on `dp_valid_i` in any non-IDLE state except LOAD.
  - A `dp_valid_i` while the count is already W·H sets `overrun_o`, and the count saturates.
  - `overrun_o` clears only on reset.
- `start_i` outside IDLE is ignored.
- Reset at any point: state → IDLE. All outputs, counters, and the live and shadow files are cleared to 0, including `overrun_o`.

## Timing
- Every output is registered; all reset values are 0.
- `start_i` at cycle t → LOAD at t+1 → `pix_ready_o` high at t+2.
- Transfer at cycle t → `valid_o`, `col_o`, `row_o` and pixels valid at t+1, held one cycle.
- Pixel outputs hold their last values when `valid_o` = 0.
- `pix_ready_o` is Moore (a function of state only). It drops the cycle after the row-end transfer.
- Minimum input cycles per frame: W·H + (H−1)·ROW_GAP.
- `frame_done_o` asserts the cycle after the counter reaches W·H.
- In continuous mode, consecutive frames are separated by exactly one LOAD cycle after `frame_done_o`.
- Shadow outputs change only on the cycle after LOAD.

## Structure
- Shared package `dfdd_ctrl_pkg`:
  - state enum
  - address-base constants A, B, R, C as functions of SCALES and NO_ZONES
  - `cfg_decode` function mapping address → (field, index, hit)
- Sub-module `dfdd_cfg_regfile`: live and shadow arrays, write decode, and the `snapshot_i` copy.
- The sequencer FSM and counters live in the top module.

## Test plan
- **Basic frame:** W=4, H=3, ROW_GAP=2. Start with `pix_valid_i` always high → 12 `valid_o` pulses with (col,row) = (0,0)…(3,2), and `pix_ready_o` low for 2 cycles after rows 0 and 1. Feed 12 `dp_valid_i` → `frame_done_o` pulse, then IDLE.
- **Upstream stalls:** toggle `pix_valid_i` randomly → no duplicated or skipped coordinates, and the pixel data matches the input order.
- **Config snapshot:** write a[1][3] = 0x3c00 (addr 18) mid-frame → `a_o[1][3]` stays unchanged until the next LOAD, then equals 0x3c00. A write to addr 60 → no change to any register.
- **Continuous mode:** `cont_i` = 1 → a second frame starts exactly 1 cycle after `frame_done_o`, with coordinates restarting at (0,0).
- **Overrun:** 13 `dp_valid_i` pulses for a 12-pixel frame → `overrun_o` = 1 and stays high through the next frame.
- **Reset mid-STREAM:** assert `rst_i` at pixel 5 → next cycle all outputs and `busy_o` are 0 and shadow outputs are 0. A new start restarts at (0,0).
